// File: rtl/tone_mixer.sv
// tone_mixer: polyphonic square-wave tone generator feeding the audio CODEC write port.
//
// Each switch gates one voice with its own half-period (in samples). Enabled voices are
// summed with signed saturation and written to both channels through a three-state
// IDLE/WRITE/WAIT handshake, one sample per CODEC slot.
//
// Optional feature: define TONE_MIXER_ENVELOPE_EN to add a per-voice linear attack/release
// gain (0..2^ENV_STEP_W) instead of instantaneous gating.
//
// Ports:
//   clock           in   system clock
//   reset           in   synchronous, active-high reset
//   switches        in   [VOICES]  bit i enables voice i, sampled at each sample strobe
//   write_ready     in   CODEC can accept a sample pair
//   write           out  one-cycle write strobe
//   writedata_left  out  [DATA_W]  left sample (two's complement)
//   writedata_right out  [DATA_W]  right sample, always equal to left
module tone_mixer #(
  parameter int unsigned                 DATA_W       = 24,
  parameter int unsigned                 VOICES       = 4,
  parameter int unsigned                 PERIOD_W     = 8,
  parameter logic [VOICES*PERIOD_W-1:0]  HALF_PERIODS = {8'd32, 8'd16, 8'd8, 8'd4},
  parameter logic [DATA_W-1:0]           AMPLITUDE    = 24'h100000,
  parameter int unsigned                 ENV_STEP_W   = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [VOICES-1:0] switches,
  input  logic              write_ready,
  output logic              write,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right
);

  localparam int unsigned SumW = DATA_W + $clog2(VOICES) + 1;

  localparam logic signed [SumW-1:0] SatMax = {{(SumW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SumW-1:0] SatMin = {{(SumW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  if (VOICES < 1 || VOICES > 8 || ENV_STEP_W < 1) begin : gen_param_check
    $error("tone_mixer: VOICES must be 1..8 and ENV_STEP_W at least 1");
  end

  typedef enum logic [1:0] {StIdle, StWrite, StWait} state_e;

  state_e state_q, state_d;
  logic   strobe;

  logic [PERIOD_W-1:0] cnt_q [VOICES];
  logic [PERIOD_W-1:0] cnt_d [VOICES];
  logic                ph_q  [VOICES];
  logic                ph_d  [VOICES];
  logic [PERIOD_W-1:0] half_eff [VOICES];
  logic [DATA_W-1:0]   mag      [VOICES];
  logic                run      [VOICES];
  logic                clr      [VOICES];

  logic signed [SumW-1:0] voice_val [VOICES];
  logic signed [SumW-1:0] sum;
  logic [DATA_W-1:0]      mix;
  logic [DATA_W-1:0]      data_q, data_d;

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    strobe  = 1'b0;
    write   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (write_ready) begin
          strobe  = 1'b1;
          state_d = StWrite;
        end
      end
      StWrite: begin
        write   = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        // Wait for the CODEC to drop ready so each slot gets exactly one sample.
        if (!write_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Per-voice gain (envelope build) or plain gating
  // ---------------------------------------------------------------------------
`ifdef TONE_MIXER_ENVELOPE_EN
  localparam logic [ENV_STEP_W:0] GMax = (ENV_STEP_W+1)'(1) << ENV_STEP_W;

  logic [ENV_STEP_W:0]          g_q   [VOICES];
  logic [ENV_STEP_W:0]          g_d   [VOICES];
  logic [ENV_STEP_W:0]          g_new [VOICES];
  logic [DATA_W+ENV_STEP_W:0]   prod  [VOICES];

  always_comb begin
    for (int i = 0; i < VOICES; i++) begin
      if (switches[i]) g_new[i] = (g_q[i] == GMax) ? g_q[i] : g_q[i] + 1'b1;
      else             g_new[i] = (g_q[i] == '0)   ? g_q[i] : g_q[i] - 1'b1;
      g_d[i]  = strobe ? g_new[i] : g_q[i];
      // The gain that results from this strobe scales this strobe's sample.
      prod[i] = (DATA_W+ENV_STEP_W+1)'(AMPLITUDE) * (DATA_W+ENV_STEP_W+1)'(g_new[i]);
      mag[i]  = prod[i][ENV_STEP_W +: DATA_W];
      // Oscillator keeps running through the release tail.
      run[i]  = (g_new[i] != '0);
      clr[i]  = !run[i];
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < VOICES; i++) begin
      if (reset) g_q[i] <= '0;
      else       g_q[i] <= g_d[i];
    end
  end
`else
  always_comb begin
    for (int i = 0; i < VOICES; i++) begin
      run[i] = switches[i];
      clr[i] = !switches[i];
      mag[i] = switches[i] ? AMPLITUDE : '0;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Voice oscillators and values
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < VOICES; i++) begin
      half_eff[i] = HALF_PERIODS[i*PERIOD_W +: PERIOD_W];
      if (half_eff[i] == '0) half_eff[i] = PERIOD_W'(1);

      cnt_d[i] = cnt_q[i];
      ph_d[i]  = ph_q[i];
      if (strobe) begin
        if (run[i]) begin
          if (cnt_q[i] == half_eff[i] - PERIOD_W'(1)) begin
            cnt_d[i] = '0;
            ph_d[i]  = ~ph_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + PERIOD_W'(1);
          end
        end else if (clr[i]) begin
          cnt_d[i] = '0;
          ph_d[i]  = 1'b0;
        end
      end

      // Value uses the pre-strobe phase; magnitude is zero for a silent voice.
      voice_val[i] = $signed({{(SumW-DATA_W){1'b0}}, mag[i]});
      if (ph_q[i]) voice_val[i] = -voice_val[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Mixer with signed saturation
  // ---------------------------------------------------------------------------
  always_comb begin
    sum = '0;
    for (int i = 0; i < VOICES; i++) begin
      sum = sum + voice_val[i];
    end
    if (sum > SatMax)      mix = SatMax[DATA_W-1:0];
    else if (sum < SatMin) mix = SatMin[DATA_W-1:0];
    else                   mix = sum[DATA_W-1:0];
    data_d = strobe ? mix : data_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      data_q  <= '0;
      for (int i = 0; i < VOICES; i++) begin
        cnt_q[i] <= '0;
        ph_q[i]  <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      for (int i = 0; i < VOICES; i++) begin
        cnt_q[i] <= cnt_d[i];
        ph_q[i]  <= ph_d[i];
      end
    end
  end

  assign writedata_left  = data_q;
  assign writedata_right = data_q;

endmodule
